// File: rtl/is_seq_ctrl_if.sv
// Job, buffer-read, datapath and result ports of the MAC column sequencer.
// The master modport belongs to the sequencer. The slave modport belongs to its environment.
interface is_seq_ctrl_if #(
  parameter int MEM_AW = 10
);
  logic              start;
  logic [MEM_AW-1:0] w_addr;
  logic [MEM_AW-1:0] i_base;
  logic [15:0]       num_vec;
  logic              busy;
  logic              done;
  logic              rd_en;
  logic [MEM_AW-1:0] rd_addr;
  logic [511:0]      rd_data;
  logic              dp_clk_en;
  logic              dp_enW;
  logic              dp_enI;
  logic [511:0]      dp_in;
  logic [31:0]       dp_out;
  logic              res_valid;
  logic [31:0]       res_data;
  logic              res_last;
  logic              res_ready;

  modport master (
    input  start, w_addr, i_base, num_vec, rd_data, dp_out, res_ready,
    output busy, done, rd_en, rd_addr, dp_clk_en, dp_enW, dp_enI, dp_in,
           res_valid, res_data, res_last
  );

  modport slave (
    output start, w_addr, i_base, num_vec, rd_data, dp_out, res_ready,
    input  busy, done, rd_en, rd_addr, dp_clk_en, dp_enW, dp_enI, dp_in,
           res_valid, res_data, res_last
  );
endinterface

// File: rtl/is_seq_ctrl.sv
// Input-stationary MAC sequencer: weight fetch, input-run issue, result capture into a FIFO.
// Strobes lag reads by 1 cycle and results are pushed PIPE_LAT+1 cycles after issue; a stalled consumer only throttles issue via credits.
module is_seq_ctrl #(
  parameter int PIPE_LAT   = 18,
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_AW     = 10
) (
  input logic          IS_CLK,
  input logic          IS_RSTN,
  is_seq_ctrl_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_FEED, S_DRAIN, S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [MEM_AW-1:0] w_addr_q, i_base_q;
  logic [15:0]       num_vec_q, vec_cnt;
  logic [CW-1:0]     fifo_cnt, inflight;
  logic              has_credit, last_beat;
  logic              issue_w, issue_i;
  logic              done_d;
  logic [511:0]      dp_in_q;
  logic [PIPE_LAT:0] tok_vld, tok_last;
  logic              push, pop;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [32:0]       fifo_mem [FIFO_DEPTH];
  logic [32:0]       head;

  // Inflight results count against credit too, so a result always has a slot waiting.
  assign has_credit = ({1'b0, fifo_cnt} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign last_beat  = (vec_cnt == num_vec_q - 16'd1);

  always_ff @(posedge IS_CLK or negedge IS_RSTN) begin
    if (!IS_RSTN) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue_w   = 1'b0;
    issue_i   = 1'b0;
    case (state)
      S_IDLE:   if (bus.start) state_nxt = S_LOAD_W;
      S_LOAD_W: begin
        issue_w   = 1'b1;
        state_nxt = (num_vec_q == 16'd0) ? S_DRAIN : S_FEED;
      end
      S_FEED: begin
        if (has_credit) begin
          issue_i = 1'b1;
          if (last_beat) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN:  if (inflight == '0) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign bus.rd_en   = issue_w | issue_i;
  assign bus.rd_addr = issue_w ? w_addr_q :
                       issue_i ? (i_base_q + MEM_AW'(vec_cnt)) : '0;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_DONE);
  assign bus.dp_clk_en = (state != S_IDLE) | done_d;
  assign bus.dp_in     = (bus.dp_enW | bus.dp_enI) ? bus.rd_data : dp_in_q;

  always_ff @(posedge IS_CLK or negedge IS_RSTN) begin
    if (!IS_RSTN) begin
      w_addr_q   <= '0;
      i_base_q   <= '0;
      num_vec_q  <= '0;
      vec_cnt    <= '0;
      bus.dp_enW <= 1'b0;
      bus.dp_enI <= 1'b0;
      dp_in_q    <= '0;
      done_d     <= 1'b0;
      tok_vld    <= '0;
      tok_last   <= '0;
    end else begin
      if (state == S_IDLE && bus.start) begin
        w_addr_q  <= bus.w_addr;
        i_base_q  <= bus.i_base;
        num_vec_q <= bus.num_vec;
        vec_cnt   <= '0;
      end else if (issue_i) begin
        vec_cnt <= vec_cnt + 16'd1;
      end
      bus.dp_enW <= issue_w;
      bus.dp_enI <= issue_i;
      dp_in_q    <= bus.dp_in;
      done_d     <= (state == S_DONE);
      tok_vld    <= {tok_vld[PIPE_LAT-1:0], issue_i};
      tok_last   <= {tok_last[PIPE_LAT-1:0], issue_i & last_beat};
    end
  end

  assign push = tok_vld[PIPE_LAT];
  assign pop  = bus.res_valid & bus.res_ready;

  always_ff @(posedge IS_CLK or negedge IS_RSTN) begin
    if (!IS_RSTN) begin
      inflight <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      case ({issue_i, push})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge IS_CLK) begin
    if (push) fifo_mem[wr_ptr] <= {tok_last[PIPE_LAT], bus.dp_out};
  end

  // Head is gated so an empty FIFO presents zeros rather than stale entries.
  assign head          = fifo_mem[rd_ptr];
  assign bus.res_valid = (fifo_cnt != '0);
  assign bus.res_data  = bus.res_valid ? head[31:0] : 32'd0;
  assign bus.res_last  = bus.res_valid & head[32];

  no_fifo_overflow: assert property (@(posedge IS_CLK) disable iff (!IS_RSTN)
    !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_is_seq_ctrl.sv
// Directed and random jobs against buffer/datapath stubs; results checked against an address/value model.
module tb_is_seq_ctrl;
  localparam int PIPE_LAT   = 18;
  localparam int FIFO_DEPTH = 8;
  localparam int MEM_AW     = 10;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  is_seq_ctrl_if #(.MEM_AW(MEM_AW)) bus ();

  is_seq_ctrl #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .MEM_AW(MEM_AW)) dut (
    .IS_CLK (clk),
    .IS_RSTN(rstn),
    .bus    (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] h(input logic [MEM_AW-1:0] a);
    return 32'(a) * 32'h9E3779B1 + 32'h0BADF00D;
  endfunction

  // Buffer stub: every word is its hash replicated across all 16 lanes.
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= {16{h(bus.rd_addr)}};

  // Datapath stub: result = lane0 + lane15 + loaded weight, PIPE_LAT cycles after dp_enI.
  logic [31:0] wreg;
  logic [31:0] pipe [PIPE_LAT];
  always @(posedge clk) begin
    if (bus.dp_enW) wreg <= bus.dp_in[31:0];
    pipe[0] <= bus.dp_enI ? (bus.dp_in[31:0] + bus.dp_in[511:480] + wreg)
                          : (32'hDEAD0000 ^ 32'(cyc));
    for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.dp_out = pipe[PIPE_LAT-1];

  int                c0 = 0;
  logic [MEM_AW-1:0] addr_q [$];
  logic [32:0]       pop_q [$];
  int                n_enW, n_enI, max_out, first_vld, first_enI, last_enI, n_vld;
  logic              ce_tr   [4096];
  logic              busy_tr [4096];

  always @(negedge clk) begin
    if (bus.rd_en) addr_q.push_back(bus.rd_addr);
    if (bus.dp_enW) n_enW = n_enW + 1;
    if (bus.dp_enI) begin
      if (first_enI < 0) first_enI = cyc - c0;
      last_enI = cyc - c0;
      n_enI    = n_enI + 1;
    end
    if (n_enI - pop_q.size() > max_out) max_out = n_enI - pop_q.size();
    if (bus.res_valid) begin
      n_vld = n_vld + 1;
      if (first_vld < 0) first_vld = cyc - c0;
    end
    if (cyc - c0 >= 0 && cyc - c0 < 4096) begin
      ce_tr[cyc-c0]   = bus.dp_clk_en;
      busy_tr[cyc-c0] = bus.busy;
    end
    if (bus.res_valid && bus.res_ready) pop_q.push_back({bus.res_last, bus.res_data});
  end

  int n_pass = 0, n_fail = 0, n_chk = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [MEM_AW-1:0] w, input logic [MEM_AW-1:0] ib, input int nv,
                         input int rel, input bit rnd, input bit poke, output int done_at);
    logic [MEM_AW-1:0] a;
    logic [31:0]       e;
    addr_q.delete();
    pop_q.delete();
    n_enW = 0; n_enI = 0; max_out = 0; first_vld = -1; first_enI = -1; last_enI = -1; n_vld = 0;
    bus.w_addr  = w;
    bus.i_base  = ib;
    bus.num_vec = 16'(nv);
    bus.start   = 1'b1;
    bus.res_ready = rnd ? 1'b1 : (rel == 0);
    c0      = cyc;
    done_at = -1;
    for (int t = 0; t < 3000 && done_at < 0; t++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) done_at = cyc - c0;
      if (rnd) bus.res_ready = ($urandom_range(0, 3) != 0);
      else     bus.res_ready = (cyc - c0 >= rel);
      if (poke && (cyc - c0 == 4 || cyc - c0 == 12)) begin
        bus.start   = 1'b1;
        bus.w_addr  = ~w;
        bus.i_base  = ib + MEM_AW'(300);
        bus.num_vec = 16'd3;
      end
      if (!rnd && rel >= 40 && cyc - c0 == rel - 1) begin
        chk("stall_inputs_issued", n_enI, FIFO_DEPTH);
        chk("stall_rd_en", bus.rd_en, 0);
        chk("stall_no_pops", pop_q.size(), 0);
        chk("stall_res_valid", bus.res_valid, 1);
      end
    end
    chk("done_seen", done_at >= 0, 1);
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    for (int t = 0; t < 400 && pop_q.size() < nv; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("rd_count", addr_q.size(), nv + 1);
    if (addr_q.size() > 0) chk("rd_addr_weight", addr_q[0], w);
    for (int k = 0; k < nv && k + 1 < addr_q.size(); k++)
      chk($sformatf("rd_addr_in%0d", k), addr_q[k+1], MEM_AW'(32'(ib) + k));
    chk("pop_count", pop_q.size(), nv);
    for (int k = 0; k < nv && k < pop_q.size(); k++) begin
      a = MEM_AW'(32'(ib) + k);
      e = h(a) + h(a) + h(w);
      chk($sformatf("result%0d", k), pop_q[k], {(k == nv - 1), e});
    end
    chk("dp_enW_count", n_enW, 1);
    chk("dp_enI_count", n_enI, nv);
    chk("credit_bound", max_out <= FIFO_DEPTH, 1);
    chk("clk_en_before", ce_tr[0], 0);
    chk("clk_en_load_w", ce_tr[1], 1);
    chk("busy_load_w", busy_tr[1], 1);
    if (done_at >= 0 && done_at + 2 < 4096) begin
      chk("clk_en_after_done", ce_tr[done_at+1], 1);
      chk("clk_en_off", ce_tr[done_at+2], 0);
      chk("busy_after_done", busy_tr[done_at+1], 0);
    end
  endtask

  int d;

  initial begin
    bus.start = 1'b0; bus.w_addr = '0; bus.i_base = '0; bus.num_vec = '0; bus.res_ready = 1'b0;
    n_enW = 0; n_enI = 0; max_out = 0; first_vld = -1; first_enI = -1; last_enI = -1; n_vld = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_clk_en", bus.dp_clk_en, 0);
    chk("rst_dp_in", bus.dp_in == '0, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_job(10'd5, 10'd100, 1, 0, 1'b0, 1'b0, d);
    chk("nv1_done_cycle", d, 23);
    chk("nv1_first_valid", first_vld, 22);

    run_job(10'd37, 10'd500, 16, 0, 1'b0, 1'b0, d);
    chk("nv16_first_enI", first_enI, 3);

    run_job(10'd200, 10'd7, 12, 60, 1'b0, 1'b0, d);

    run_job(10'd9, 10'd33, 0, 0, 1'b0, 1'b0, d);
    chk("nv0_valid_cycles", n_vld, 0);

    run_job(10'd3, 10'd1020, 6, 0, 1'b0, 1'b1, d);
    chk("wrap_done_cycle", d, 28);

    // Reset in the middle of an input run.
    bus.w_addr = 10'd11; bus.i_base = 10'd50; bus.num_vec = 16'd20; bus.res_ready = 1'b1;
    bus.start = 1'b1;
    c0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("mid_busy_before_reset", bus.busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rd_en", bus.rd_en, 0);
    chk("mid_rst_rd_addr", bus.rd_addr, 0);
    chk("mid_rst_clk_en", bus.dp_clk_en, 0);
    chk("mid_rst_enW", bus.dp_enW, 0);
    chk("mid_rst_enI", bus.dp_enI, 0);
    chk("mid_rst_dp_in", bus.dp_in == '0, 1);
    chk("mid_rst_res", {bus.res_valid, bus.res_last, bus.res_data}, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    n_vld = 0;
    repeat (30) @(posedge clk);
    #1;
    chk("post_reset_no_valid", n_vld, 0);
    chk("post_reset_idle", bus.busy, 0);

    for (int j = 0; j < 4; j++)
      run_job(MEM_AW'($urandom_range(0, 1023)), MEM_AW'($urandom_range(0, 1023)),
              $urandom_range(1, 24), 0, 1'b1, 1'b0, d);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
